// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder family (adder, future subtractor/accumulator).
package adder_pkg;

  localparam int unsigned MAX_W = 64;

  // Per-stage record; fields are sized for the widest supported datapath.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [MAX_W-1:0] partial_sum;
    logic [MAX_W-1:0] a_rem;
    logic [MAX_W-1:0] b_rem;
  } stage_t;

  function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One pipeline stage: registered CHUNK-bit slice add plus valid/ready advance logic.
module adder_stage
  import adder_pkg::*;
#(
  parameter int unsigned CHUNK = 4,
  parameter int unsigned IDX   = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t up,
  output logic   up_ready,
  input  logic   dn_ready,
  output stage_t dn
);

  localparam int unsigned SHIFT = IDX * CHUNK;

  logic [CHUNK:0]   c;
  logic [CHUNK-1:0] s;
  logic [CHUNK-1:0] s1;
  logic [CHUNK-1:0] c1;
  logic [CHUNK-1:0] c2;

  assign c[0] = up.carry;

  // Two half adders per bit form a full adder; the slice always sits at the bottom of a_rem/b_rem.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    half_adder u_ha0 (.a(up.a_rem[i]), .b(up.b_rem[i]), .sum(s1[i]), .carry(c1[i]));
    half_adder u_ha1 (.a(s1[i]),       .b(c[i]),        .sum(s[i]),  .carry(c2[i]));
    assign c[i+1] = c1[i] | c2[i];
  end

  assign up_ready = !dn.valid || dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn <= '0;
    end else if (up_ready) begin
      dn.valid <= up.valid;
      if (up.valid) begin
        dn.carry       <= c[CHUNK];
        dn.partial_sum <= up.partial_sum | (MAX_W'(s) << SHIFT);
        dn.a_rem       <= up.a_rem >> CHUNK;
        dn.b_rem       <= up.b_rem >> CHUNK;
      end
    end
  end

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep valid/ready pipelined adder; signed overflow output with `PIPELINED_ADDER_OVF_EN.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

  if (STAGES < 1) begin : g_bad_stages
    $error("pipelined_adder: STAGES must be >= 1");
  end else if (WIDTH % STAGES != 0) begin : g_bad_split
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end else if (WIDTH > MAX_W) begin : g_bad_width
    $error("pipelined_adder: WIDTH exceeds MAX_W");
  end

  stage_t head;
  stage_t link [STAGES];
  logic   rdy  [STAGES];

  always_comb begin
    head             = '0;
    head.valid       = in_valid;
    head.carry       = cin;
    head.a_rem       = MAX_W'(a);
    head.b_rem       = MAX_W'(b);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t up;
    logic   dn_ready;

    if (k == 0) begin : g_first
      assign up = head;
    end else begin : g_mid
      assign up = link[k-1];
    end

    if (k == STAGES - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_body
      assign dn_ready = rdy[k+1];
    end

    adder_stage #(.CHUNK(CHUNK), .IDX(k)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up       (up),
      .up_ready (rdy[k]),
      .dn_ready (dn_ready),
      .dn       (link[k])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = link[STAGES-1].valid;
  assign sum       = link[STAGES-1].partial_sum[WIDTH-1:0];
  assign cout      = link[STAGES-1].carry;

`ifdef PIPELINED_ADDER_OVF_EN
  logic last_valid;
  logic last_sa;
  logic last_sb;
  logic sign_a;
  logic sign_b;

  // Operand MSBs are the top bit of the final slice as it enters the last stage.
  if (STAGES == 1) begin : g_sign_src
    assign last_valid = head.valid;
    assign last_sa    = head.a_rem[CHUNK-1];
    assign last_sb    = head.b_rem[CHUNK-1];
  end else begin : g_sign_src
    assign last_valid = link[STAGES-2].valid;
    assign last_sa    = link[STAGES-2].a_rem[CHUNK-1];
    assign last_sb    = link[STAGES-2].b_rem[CHUNK-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else if (rdy[STAGES-1] && last_valid) begin
      sign_a <= last_sa;
      sign_b <= last_sb;
    end
  end

  assign ovf = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
`endif

endmodule
